// File: rtl/senha_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : senha_lock_ctrl
//  Purpose  : Access policy around the 4-button password checker. Turns raw
//             button levels into press pulses, consumes checker verdicts,
//             holds the lock open for a fixed time, and imposes a timed
//             lockout after too many consecutive wrong codes.
//  Revision : 1.0 - initial release
// ============================================================================
module senha_lock_ctrl #(
  parameter int MAX_FAIL    = 3,
  parameter int OPEN_CYCLES = 8,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          b1,
  input  logic                          b2,
  input  logic                          b3,
  input  logic                          b4,
  input  logic                          acertou,
  input  logic                          errou,
  output logic                          p1,
  output logic                          p2,
  output logic                          p3,
  output logic                          p4,
  output logic                          chk_clr,
  output logic                          aberto,
  output logic                          bloqueado,
  output logic [$clog2(MAX_FAIL+1)-1:0] falhas
);

  localparam int c_FW      = $clog2(MAX_FAIL + 1);
  localparam int c_TMAX    = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int c_TW_RAW  = $clog2(c_TMAX);
  localparam int c_TW      = (c_TW_RAW < 1) ? 1 : c_TW_RAW;

  localparam logic [c_TW-1:0] c_OPEN_LOAD = c_TW'(OPEN_CYCLES - 1);
  localparam logic [c_TW-1:0] c_LOCK_LOAD = c_TW'(LOCK_CYCLES - 1);
  localparam logic [c_FW:0]   c_MAX_FAIL  = (c_FW + 1)'(MAX_FAIL);

  localparam logic [1:0] S_ARMED  = 2'd0;
  localparam logic [1:0] S_OPEN   = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [c_TW-1:0] r_timer;
  logic [c_TW-1:0] w_timer_nxt;
  logic [c_FW-1:0] r_falhas;
  logic [c_FW-1:0] w_falhas_nxt;
  logic            r_clr;
  logic            w_clr_nxt;
  logic [3:0]      r_bprev;
  logic [3:0]      r_p;
  logic [3:0]      w_p_nxt;
  logic            r_aberto;
  logic            w_aberto_nxt;
  logic            r_bloq;
  logic            w_bloq_nxt;
  logic [3:0]      w_btn;
  logic [3:0]      w_edge;
  logic [c_FW:0]   w_falhas_inc;

  assign w_btn        = {b4, b3, b2, b1};
  assign w_edge       = w_btn & ~r_bprev;
  assign w_falhas_inc = {1'b0, r_falhas} + 1'b1;

  // State register plus all registered outputs; history resets high so a
  // button held through reset never yields a pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_ARMED;
      r_timer  <= '0;
      r_falhas <= '0;
      r_clr    <= 1'b1;
      r_bprev  <= 4'hF;
      r_p      <= 4'h0;
      r_aberto <= 1'b0;
      r_bloq   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_falhas <= w_falhas_nxt;
      r_clr    <= w_clr_nxt;
      r_bprev  <= w_btn;
      r_p      <= w_p_nxt;
      r_aberto <= w_aberto_nxt;
      r_bloq   <= w_bloq_nxt;
    end
  end

  // Next-state logic: verdict handling in ARMED, countdown in OPEN/LOCKED.
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_falhas_nxt = r_falhas;
    w_clr_nxt    = 1'b0;
    case (r_state)
      S_ARMED: begin
        if (errou) begin
          w_clr_nxt = 1'b1;
          if (w_falhas_inc == c_MAX_FAIL) begin
            w_state_nxt  = S_LOCKED;
            w_timer_nxt  = c_LOCK_LOAD;
            w_falhas_nxt = '0;
          end else begin
            w_falhas_nxt = w_falhas_inc[c_FW-1:0];
          end
        end else if (acertou) begin
          w_clr_nxt    = 1'b1;
          w_state_nxt  = S_OPEN;
          w_timer_nxt  = c_OPEN_LOAD;
          w_falhas_nxt = '0;
        end
      end
      S_OPEN, S_LOCKED: begin
        if (r_timer == '0) begin
          w_state_nxt = S_ARMED;
          w_clr_nxt   = 1'b1;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_ARMED;
        w_timer_nxt = '0;
        w_clr_nxt   = 1'b1;
      end
    endcase
  end

  // Output logic: pulses only forwarded while staying in ARMED, mode flags
  // follow the upcoming state so they line up with it.
  always_comb begin
    w_p_nxt      = 4'h0;
    w_aberto_nxt = (w_state_nxt == S_OPEN);
    w_bloq_nxt   = (w_state_nxt == S_LOCKED);
    if ((r_state == S_ARMED) && (w_state_nxt == S_ARMED)) begin
      w_p_nxt = w_edge;
    end
  end

  assign p1        = r_p[0];
  assign p2        = r_p[1];
  assign p3        = r_p[2];
  assign p4        = r_p[3];
  assign chk_clr   = r_clr;
  assign aberto    = r_aberto;
  assign bloqueado = r_bloq;
  assign falhas    = r_falhas;

endmodule
`default_nettype wire

// File: tb/tb_senha_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_senha_lock_ctrl
//  Purpose  : Directed self-checking bench for senha_lock_ctrl with default
//             parameters (MAX_FAIL=3, OPEN_CYCLES=8, LOCK_CYCLES=16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_senha_lock_ctrl;

  logic       clk;
  logic       reset;
  logic       b1, b2, b3, b4;
  logic       acertou, errou;
  logic       p1, p2, p3, p4;
  logic       chk_clr, aberto, bloqueado;
  logic [1:0] falhas;

  int n_cmp;
  int n_bad;

  senha_lock_ctrl #(
    .MAX_FAIL   (3),
    .OPEN_CYCLES(8),
    .LOCK_CYCLES(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .b1       (b1),
    .b2       (b2),
    .b3       (b3),
    .b4       (b4),
    .acertou  (acertou),
    .errou    (errou),
    .p1       (p1),
    .p2       (p2),
    .p3       (p3),
    .p4       (p4),
    .chk_clr  (chk_clr),
    .aberto   (aberto),
    .bloqueado(bloqueado),
    .falhas   (falhas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs and outputs handled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic verdict(input logic ok, input logic bad);
    acertou = ok;
    errou   = bad;
    tick();
    acertou = 1'b0;
    errou   = 1'b0;
  endtask

  function automatic int pbus();
    return {28'd0, p4, p3, p2, p1};
  endfunction

  initial begin
    int cnt;
    int guard;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    {b1, b2, b3, b4} = 4'b0000;
    b1 = 1'b1;
    acertou = 1'b0;
    errou = 1'b0;

    // Reset with b1 held
    tick();
    tick();
    check_val("rst_chk_clr", chk_clr, 1);
    check_val("rst_aberto", aberto, 0);
    check_val("rst_bloq", bloqueado, 0);
    check_val("rst_falhas", falhas, 0);
    check_val("rst_p", pbus(), 0);
    reset = 1'b1;
    tick();
    check_val("held_no_pulse", pbus(), 0);
    check_val("post_rst_clr", chk_clr, 0);
    b1 = 1'b0;
    tick();
    check_val("release_no_pulse", pbus(), 0);
    b1 = 1'b1;
    tick();
    check_val("press_p1", pbus(), 1);
    tick();
    check_val("press_p1_one", pbus(), 0);
    b1 = 1'b0;
    tick();

    // Correct code: open for 8 cycles, buttons masked
    verdict(1'b1, 1'b0);
    check_val("open_aberto", aberto, 1);
    check_val("open_clr", chk_clr, 1);
    cnt = 1;
    guard = 0;
    while (aberto && guard < 40) begin
      if (cnt == 2) b2 = 1'b1;
      if (cnt == 4) b2 = 1'b0;
      tick();
      guard++;
      if (aberto) begin
        cnt++;
        check_val("open_mask", pbus(), 0);
        check_val("open_noclr", chk_clr, 0);
      end
    end
    check_val("open_dwell", cnt, 8);
    check_val("open_exit_clr", chk_clr, 1);
    check_val("open_exit_falhas", falhas, 0);
    tick();
    check_val("open_exit_clr_one", chk_clr, 0);

    // Wrong codes: 1, 2, then lockout
    verdict(1'b0, 1'b1);
    check_val("err1_falhas", falhas, 1);
    check_val("err1_clr", chk_clr, 1);
    tick();
    check_val("err1_clr_one", chk_clr, 0);
    verdict(1'b0, 1'b1);
    check_val("err2_falhas", falhas, 2);
    check_val("err2_clr", chk_clr, 1);
    check_val("err2_bloq", bloqueado, 0);
    tick();
    verdict(1'b0, 1'b1);
    check_val("err3_bloq", bloqueado, 1);
    check_val("err3_falhas", falhas, 0);
    check_val("err3_clr", chk_clr, 1);
    cnt = 1;
    guard = 0;
    while (bloqueado && guard < 60) begin
      if (cnt == 3) b3 = 1'b1;
      if (cnt == 5) b3 = 1'b0;
      if (cnt == 7) b3 = 1'b1;
      if (cnt == 8) b3 = 1'b0;
      tick();
      guard++;
      if (bloqueado) begin
        cnt++;
        check_val("lock_mask", pbus(), 0);
      end
    end
    check_val("lock_dwell", cnt, 16);
    check_val("lock_exit_clr", chk_clr, 1);
    check_val("lock_exit_falhas", falhas, 0);
    tick();

    // Two errors then correct clears the count
    verdict(1'b0, 1'b1);
    tick();
    verdict(1'b0, 1'b1);
    tick();
    check_val("pre_ok_falhas", falhas, 2);
    verdict(1'b1, 1'b0);
    check_val("ok_after_err_open", aberto, 1);
    check_val("ok_after_err_falhas", falhas, 0);
    guard = 0;
    while (aberto && guard < 40) begin
      tick();
      guard++;
    end
    check_val("ok_after_err_exit", aberto, 0);
    tick();
    verdict(1'b0, 1'b1);
    check_val("single_err_falhas", falhas, 1);
    check_val("single_err_nolock", bloqueado, 0);
    tick();

    // Both verdicts together count as a failure
    verdict(1'b1, 1'b1);
    check_val("both_falhas", falhas, 2);
    check_val("both_aberto", aberto, 0);
    tick();

    // Lockout, then reset at its 5th cycle
    verdict(1'b0, 1'b1);
    check_val("lock2_bloq", bloqueado, 1);
    for (int i = 0; i < 4; i++) tick();
    check_val("lock2_c5", bloqueado, 1);
    reset = 1'b0;
    tick();
    check_val("rst_lock_bloq", bloqueado, 0);
    check_val("rst_lock_falhas", falhas, 0);
    check_val("rst_lock_clr", chk_clr, 1);
    reset = 1'b1;
    tick();
    check_val("rst_lock_clr_off", chk_clr, 0);
    verdict(1'b1, 1'b0);
    check_val("rst_lock_reopen", aberto, 1);
    check_val("rst_lock_reopen_clr", chk_clr, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
